// File: rtl/hdmi_pkg.sv
// hdmi_pkg: TMDS control/guard symbol constants, period classes and control-code lookup.
package hdmi_pkg;
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;
  localparam logic [9:0] GUARD_VID_C02 = 10'b1011001100;
  localparam logic [9:0] GUARD_VID_C1 = 10'b0100110011;
  typedef enum logic [1:0] {P_CTRL, P_PREAMBLE, P_GUARD, P_VIDEO} period_t;
  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    return c[1] ? (c[0] ? CTRL_11 : CTRL_10) : (c[0] ? CTRL_01 : CTRL_00);
  endfunction
endpackage

// File: rtl/tmds_channel.sv
// tmds_channel: one TMDS lane; DVI 8b/10b video encode with running disparity, or control/guard symbol.
module tmds_channel
  import hdmi_pkg::*;
(
  input  logic       clk_h,
  input  logic       rst_h_n,
  input  logic [7:0] data_i,
  input  logic [1:0] ctrl_i,
  input  period_t    period_i,
  input  logic       guard_sel_i,
  output logic [9:0] sym_o
);
  logic [8:0] qm;
  logic [3:0] n1d, n1q, n0q;
  logic use_xnor;
  logic signed [4:0] cnt_q, cnt_d, cnt_v, diff;
  logic [9:0] sym_q, sym_d, sym_v;
  always_comb begin
    n1d = '0;
    for (int i = 0; i < 8; i++) n1d += {3'd0, data_i[i]};
    use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !data_i[0]);
    qm = '0;
    qm[0] = data_i[0];
    for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ data_i[i] ^ use_xnor;
    qm[8] = ~use_xnor;
    n1q = '0;
    for (int i = 0; i < 8; i++) n1q += {3'd0, qm[i]};
    n0q = 4'd8 - n1q;
    diff = $signed({1'b0, n1q}) - $signed({1'b0, n0q});
    sym_v = {1'b0, qm[8], qm[7:0]};
    cnt_v = cnt_q - $signed({3'd0, ~qm[8], 1'b0}) + diff;
    if (cnt_q == 5'sd0 || n1q == n0q) begin
      sym_v = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_v = qm[8] ? cnt_q + diff : cnt_q - diff;
    end else if ((!cnt_q[4] && n1q > n0q) || (cnt_q[4] && n0q > n1q)) begin
      sym_v = {1'b1, qm[8], ~qm[7:0]};
      cnt_v = cnt_q + $signed({3'd0, qm[8], 1'b0}) - diff;
    end
    sym_d = period_i == P_VIDEO ? sym_v :
            period_i == P_GUARD ? (guard_sel_i ? GUARD_VID_C1 : GUARD_VID_C02) : ctrl_code(ctrl_i);
    cnt_d = period_i == P_VIDEO ? cnt_v : 5'sd0;
  end
  always_ff @(posedge clk_h or negedge rst_h_n) begin
    if (!rst_h_n) begin
      sym_q <= CTRL_00;
      cnt_q <= 5'sd0;
    end else begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end
  assign sym_o = sym_q;
endmodule

// File: rtl/hdmi_tmds_encoder.sv
// hdmi_tmds_encoder: classifies scan position into period/syncs (S1) and TMDS-encodes three lanes (S2).
module hdmi_tmds_encoder
  import hdmi_pkg::*;
#(
  parameter int OSCREEN_WIDTH  = 720,
  parameter int OSCREEN_HEIGHT = 480,
  parameter int OFRAME_WIDTH   = 858,
  parameter int OFRAME_HEIGHT  = 525,
  parameter int HSYNC_START    = 736,
  parameter int HSYNC_LEN      = 62,
  parameter int VSYNC_START    = 489,
  parameter int VSYNC_LEN      = 6,
  parameter bit SYNC_ACTIVE    = 1'b0,
  parameter bit HDMI_MODE      = 1'b1
) (
  input  logic        clk_h,
  input  logic        rst_h_n,
  input  logic [9:0]  hx,
  input  logic [9:0]  hy,
  input  logic [23:0] rgb_h,
  output logic [9:0]  tmds_ch0,
  output logic [9:0]  tmds_ch1,
  output logic [9:0]  tmds_ch2,
  output logic        de
);
  localparam logic [10:0] SW = 11'(OSCREEN_WIDTH);
  localparam logic [10:0] SH = 11'(OSCREEN_HEIGHT);
  localparam logic [10:0] FW = 11'(OFRAME_WIDTH);
  localparam logic [10:0] FH = 11'(OFRAME_HEIGHT);
  localparam logic [10:0] HS = 11'(HSYNC_START);
  localparam logic [10:0] HE = 11'(HSYNC_START + HSYNC_LEN);
  localparam logic [10:0] VS = 11'(VSYNC_START);
  localparam logic [10:0] VE = 11'(VSYNC_START + VSYNC_LEN);
  logic [10:0] x, y;
  logic nla, hs_d, vs_d, hs_q, vs_q, de_q;
  period_t period_d, period_q;
  logic [23:0] rgb_q;
  always_comb begin
    x = {1'b0, hx};
    y = {1'b0, hy};
    nla = (y == FH - 11'd1) || (y + 11'd1 < SH);
    hs_d = (x >= HS && x < HE) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_d = (y >= VS && y < VE) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    period_d = (x < SW && y < SH) ? P_VIDEO :
               (HDMI_MODE && nla && x >= FW - 11'd2 && x <= FW - 11'd1) ? P_GUARD :
               (HDMI_MODE && nla && x >= FW - 11'd10 && x <= FW - 11'd3) ? P_PREAMBLE : P_CTRL;
  end
  // Syncs reset to 0 so the symbol emitted one clock after release is still ctrl 00.
  always_ff @(posedge clk_h or negedge rst_h_n) begin
    if (!rst_h_n) begin
      period_q <= P_CTRL;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      rgb_q    <= '0;
      de_q     <= 1'b0;
    end else begin
      period_q <= period_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      rgb_q    <= rgb_h;
      de_q     <= period_q == P_VIDEO;
    end
  end
  tmds_channel u_ch0 (.clk_h(clk_h), .rst_h_n(rst_h_n), .data_i(rgb_q[7:0]), .ctrl_i({vs_q, hs_q}),
                      .period_i(period_q), .guard_sel_i(1'b0), .sym_o(tmds_ch0));
  tmds_channel u_ch1 (.clk_h(clk_h), .rst_h_n(rst_h_n), .data_i(rgb_q[15:8]),
                      .ctrl_i({1'b0, period_q == P_PREAMBLE}), .period_i(period_q),
                      .guard_sel_i(1'b1), .sym_o(tmds_ch1));
  tmds_channel u_ch2 (.clk_h(clk_h), .rst_h_n(rst_h_n), .data_i(rgb_q[23:16]), .ctrl_i(2'b00),
                      .period_i(period_q), .guard_sel_i(1'b0), .sym_o(tmds_ch2));
  assign de = de_q;
endmodule
